// File: rtl/ipdc_pkg.sv
// Shared constants for the ipdc display packer: pixel width, window
// size codes, tag bit positions inside a FIFO entry and the framing FSM
// state encoding.
package ipdc_pkg;

    localparam int unsigned PIX_W   = 24;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned ENTRY_W = PIX_W + TAG_W;

    localparam logic [1:0] WIN_2X2  = 2'd0;
    localparam logic [1:0] WIN_4X4  = 2'd1;
    localparam logic [1:0] WIN_8X8  = 2'd2;
    localparam logic [1:0] WIN_RSVD = 2'd3;

    // Tag bits sit directly above the pixel in each FIFO entry
    localparam int unsigned TAG_SOF = PIX_W + 0;
    localparam int unsigned TAG_EOF = PIX_W + 1;
    localparam int unsigned TAG_SOL = PIX_W + 2;
    localparam int unsigned TAG_EOL = PIX_W + 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } wr_state_t;

    // Window edge length for a size code; the reserved code behaves as 4x4
    function automatic logic [3:0] win_edge(input logic [1:0] code);
        case (code)
            WIN_2X2: win_edge = 4'd2;
            WIN_8X8: win_edge = 4'd8;
            default: win_edge = 4'd4;
        endcase
    endfunction

endpackage

// File: rtl/ipdc_disp_packer_if.sv
// Downstream display stream: valid/ready handshake carrying a pixel and
// its frame/line tags. The packer drives it through the master modport.
interface ipdc_disp_packer_if;

    logic                       o_pix_valid;
    logic [ipdc_pkg::PIX_W-1:0] o_pix_data;
    logic                       o_sof;
    logic                       o_eof;
    logic                       o_sol;
    logic                       o_eol;
    logic                       i_pix_ready;

    modport master (
        output o_pix_valid,
        output o_pix_data,
        output o_sof,
        output o_eof,
        output o_sol,
        output o_eol,
        input  i_pix_ready
    );

    modport slave (
        input  o_pix_valid,
        input  o_pix_data,
        input  o_sof,
        input  o_eof,
        input  o_sol,
        input  o_eol,
        output i_pix_ready
    );

endinterface

// File: rtl/ipdc_sync_fifo.sv
// Single-clock FIFO with occupancy count. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; otherwise it is
// ignored and the caller is expected to flag the loss.
module ipdc_sync_fifo #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign wr_en   = push && (!full || pop);
    assign rd_en   = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array, written only on an accepted push
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap modulo DEPTH; count tracks occupancy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ipdc_disp_packer.sv
// Frames the unthrottled ipdc pixel stream into NxN windows, tags each
// pixel with SOF/EOF/SOL/EOL and buffers it for a ready-throttled display
// sink. Pixels arriving into a full buffer are dropped and flagged on a
// sticky overflow bit, but still advance the framing counters.
module ipdc_disp_packer
    import ipdc_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_pix_valid,
    input  logic [PIX_W-1:0]   i_pix_data,
    input  logic [1:0]         i_win_size,
    ipdc_disp_packer_if.master disp,
    output logic               o_ovf,
    input  logic               i_ovf_clr
);

    localparam int unsigned    CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(FIFO_DEPTH);

    wr_state_t          state_q;
    logic [3:0]         n_q;
    logic [2:0]         col_q;
    logic [2:0]         row_q;

    logic [3:0]         n_c;
    logic [2:0]         col_c;
    logic [2:0]         row_c;
    logic               last_col;
    logic               last_row;
    logic               tag_sof;
    logic               tag_sol;

    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;
    logic [ENTRY_W-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               pop;
    logic               ovf_set;

    // Position of the incoming pixel: a fresh frame starts at (0,0) with
    // the live window size, otherwise the latched size and counters apply
    always_comb begin
        n_c     = n_q;
        col_c   = col_q;
        row_c   = row_q;
        tag_sof = 1'b0;
        if (state_q == ST_IDLE) begin
            n_c     = win_edge(i_win_size);
            col_c   = '0;
            row_c   = '0;
            tag_sof = 1'b1;
        end
        tag_sol  = (col_c == '0);
        last_col = ({1'b0, col_c} == (n_c - 4'd1));
        last_row = ({1'b0, row_c} == (n_c - 4'd1));
    end

    assign wr_entry = {last_col, tag_sol, last_col && last_row, tag_sof, i_pix_data};

    // Framing FSM: advances on every upstream pixel, accepted or dropped
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            n_q     <= 4'd4;
            col_q   <= '0;
            row_q   <= '0;
        end else if (i_pix_valid) begin
            n_q <= n_c;
            if (last_col && last_row) begin
                state_q <= ST_IDLE;
                col_q   <= '0;
                row_q   <= '0;
            end else begin
                state_q <= ST_FRAME;
                if (last_col) begin
                    col_q <= '0;
                    row_q <= row_c + 3'd1;
                end else begin
                    col_q <= col_c + 3'd1;
                end
            end
        end
    end

    ipdc_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push    (i_pix_valid),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign pop     = disp.o_pix_valid && disp.i_pix_ready;
    assign ovf_set = i_pix_valid && fifo_full && !pop;

    // Storage is not reset, so the head is masked to zero while empty
    assign head             = fifo_empty ? '0 : rd_entry;
    assign disp.o_pix_valid = !fifo_empty;
    assign disp.o_pix_data  = head[PIX_W-1:0];
    assign disp.o_sof       = head[TAG_SOF];
    assign disp.o_eof       = head[TAG_EOF];
    assign disp.o_sol       = head[TAG_SOL];
    assign disp.o_eol       = head[TAG_EOL];

    // Sticky overflow; a new drop wins over a coincident clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ovf <= 1'b0;
        end else if (ovf_set) begin
            o_ovf <= 1'b1;
        end else if (i_ovf_clr) begin
            o_ovf <= 1'b0;
        end
    end

    // Occupancy must never exceed the buffer depth
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (fifo_count <= MAX_CNT);
        end
    end

endmodule

// File: doc/ipdc_disp_packer.md
IPDC_DISP_PACKER -- requirements
Module: ipdc_disp_packer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 16, meaning the number of pixel entries buffered between the ipdc output and the display sink.
REQ-002 The block SHALL have port i_clk, input, 1 bit: clock; all logic SHALL be rising-edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port i_pix_valid, input, 1 bit: upstream (ipdc o_out_valid) pixel strobe, with no backpressure.
REQ-005 The block SHALL have port i_pix_data, input, 24 bits: upstream pixel {R[23:16],G[15:8],B[7:0]}.
REQ-006 The block SHALL have port i_win_size, input, 2 bits: window edge code 0=2x2, 1=4x4, 2=8x8, 3=reserved, treated as 4x4.
REQ-007 The block SHALL have port o_pix_valid, output, 1 bit: downstream pixel valid.
REQ-008 The block SHALL have port o_pix_data, output, 24 bits: downstream pixel.
REQ-009 The block SHALL have port o_sof / o_eof / o_sol / o_eol, outputs, 1 bit each: start/end of frame and start/end of line tags, qualified by o_pix_valid.
REQ-010 The block SHALL have port i_pix_ready, input, 1 bit: downstream ready.
REQ-011 The block SHALL have port o_ovf, output, 1 bit: sticky overflow flag.
REQ-012 The block SHALL have port i_ovf_clr, input, 1 bit: synchronous clear of o_ovf.

Function
REQ-013 The write-side FSM SHALL have states IDLE and FRAME.
REQ-014 In IDLE, an i_pix_valid SHALL latch i_win_size as the frame size N (2/4/8), tag the pixel SOF and SOL, zero col/row counters, and move to FRAME; in the same cycle i_win_size SHALL be ignored once latched, until the FSM returns to IDLE.
REQ-015 Each accepted pixel SHALL advance col; col==N-1 SHALL set EOL and wrap col to 0 with row+1; col==0 SHALL set SOL.
REQ-016 The pixel at row==N-1, col==N-1 SHALL be tagged EOF and return the FSM to IDLE; for N=2 the frame SHALL be 4 pixels, for N=4 16 pixels, and for N=8 64 pixels.
REQ-017 Pixels and their four tag bits SHALL be written into a FIFO of FIFO_DEPTH entries, 28 bits wide.
REQ-018 A write SHALL be accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-019 A write that is not accepted SHALL be dropped, SHALL set o_ovf, and SHALL still advance the col/row/FSM counters so that frame framing stays aligned.
REQ-020 When i_ovf_clr and a new overflow coincide, o_ovf SHALL remain 1.
REQ-021 The read side SHALL drive o_pix_valid=1 whenever the FIFO is non-empty; o_pix_data and the tags SHALL reflect the head entry.
REQ-022 A pop SHALL occur when o_pix_valid && i_pix_ready.
REQ-023 Outputs SHALL be held stable while o_pix_valid=1 && i_pix_ready=0.
REQ-024 A pixel written at edge k into an empty FIFO SHALL appear on o_pix_valid after edge k, with no same-cycle bypass.
REQ-025 Simultaneous push and pop SHALL leave occupancy unchanged.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 Full and empty SHALL be derived from a count of width clog2(FIFO_DEPTH)+1.

Reset
REQ-028 Asserting i_rst_n low at any time, including mid-frame, SHALL asynchronously force: FSM=IDLE, col=row=0, N=4, FIFO empty, o_pix_valid=0, o_pix_data=0, all tags=0, o_ovf=0.
REQ-029 Pixels buffered before reset SHALL be discarded.
REQ-030 The first i_pix_valid after reset release SHALL be treated as SOF.

Structure
REQ-031 Package ipdc_pkg SHALL hold the pixel width (24), the win_size code constants, the tag bit positions, and the FSM state encoding.
REQ-032 The FIFO SHALL be a separate sub-module, ipdc_sync_fifo (parameterised width/depth, push/pop/full/empty/count).
REQ-033 Framing FSM and overflow logic SHALL reside in ipdc_disp_packer.

Verification
REQ-034 A bench SHALL cover: win_size=1, 16 consecutive pixels 0x000000..0x00000F, ready=1 -> 16 outputs in order; SOF on 0x000000; SOL on 0x0,0x4,0x8,0xC; EOL on 0x3,0x7,0xB,0xF; EOF on 0x00000F; first o_pix_valid one cycle after first input.
REQ-035 A bench SHALL cover: win_size=0, 4 pixels 0xA0A0A0..0xA3A3A3 -> EOL on the 2nd and 4th pixel, EOF on the 4th; then win_size=2, 64 pixels -> EOF on the 64th pixel only.
REQ-036 A bench SHALL cover: ready=0, 20 pixels with win_size=2 -> first 16 stored, o_ovf=1 from the 17th; after ready=1, exactly 16 pixels out; the next frame's SOF still lands after 64 input pixels.
REQ-037 A bench SHALL cover: FIFO full, ready=1, and a new pixel in the same cycle -> pixel accepted, o_ovf stays 0, count stays 16.
REQ-038 A bench SHALL cover: i_win_size changed 1->2 mid-frame (after pixel 5) -> framing stays 4x4 through pixel 16; the next frame uses 8x8.
REQ-039 A bench SHALL cover: reset asserted after pixel 7 of a 4x4 frame, then 16 new pixels -> all outputs 0 during reset; the new pixel 1 carries SOF; no pre-reset pixels emerge.
